// File: rtl/decade_chain_ctrl_pkg.sv
// decade_chain_ctrl_pkg: state encoding and digit-chain mode/direction constants
package decade_chain_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
  localparam logic MODE_BCD = 1'b0;
  localparam logic MODE_HEX = 1'b1;
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
endpackage

// File: rtl/decade_chain_ctrl_btn_sync_edge.sv
// btn_sync_edge: two-flop synchronizer followed by a registered rising-edge pulse
module btn_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic i_btn,
  output logic o_rise
);
  logic r_s1, r_s2, r_s3, r_rise;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s3   <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_s1   <= i_btn;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_rise <= r_s2 & ~r_s3;
    end
  assign o_rise = r_rise;
endmodule

// File: rtl/decade_chain_ctrl.sv
// decade_chain_ctrl: run/pause/clear FSM and prescaled count-enable tick for a digit-counter chain
module decade_chain_ctrl
  import decade_chain_ctrl_pkg::*;
#(
  parameter int CLK_HZ  = 100000000,
  parameter int TICK_HZ = 10,
  parameter int DIV_W   = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  input  logic       sw_mode,
  input  logic       sw_dir,
  input  logic       sw_oneshot,
  input  logic       chain_terminal,
  output logic       cnt_enable,
  output logic       cnt_clear,
  output logic       cnt_mode,
  output logic       cnt_direction,
  output logic       running,
  output logic       done,
  output logic [1:0] state
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam logic [DIV_W-1:0] DIV_M1 = DIV_W'(DIV - 1);

  logic w_start, w_clr, w_due, w_mode_s, w_dir_s, w_os_s;
  logic [2:0] r_sw_s1, r_sw_s2;
  logic [DIV_W-1:0] r_pre;
  logic r_en, r_clr, r_mode, r_dir;
  state_t r_state, w_next;

  btn_sync_edge u_start (.clk(clk), .reset_n(reset_n), .i_btn(btn_start_stop), .o_rise(w_start));
  btn_sync_edge u_clear (.clk(clk), .reset_n(reset_n), .i_btn(btn_clear), .o_rise(w_clr));

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_sw_s1 <= '0;
      r_sw_s2 <= '0;
    end else begin
      r_sw_s1 <= {sw_oneshot, sw_dir, sw_mode};
      r_sw_s2 <= r_sw_s1;
    end
  assign {w_os_s, w_dir_s, w_mode_s} = r_sw_s2;
  assign w_due = (r_state == ST_RUN) && (r_pre == DIV_M1);

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;

  // clear beats every other event, including a simultaneous start edge
  always_comb begin
    w_next = r_state;
    if (w_clr) w_next = ST_IDLE;
    else
      case (r_state)
        ST_IDLE:  w_next = w_start ? ST_RUN : ST_IDLE;
        ST_RUN:   w_next = w_start ? ST_PAUSE : (w_due && w_os_s && chain_terminal) ? ST_DONE : ST_RUN;
        ST_PAUSE: w_next = w_start ? ST_RUN : ST_PAUSE;
        default:  w_next = ST_DONE;
      endcase
  end

  // a due tick is only issued if the chain stays in RUN through that edge
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_pre  <= '0;
      r_en   <= 1'b0;
      r_clr  <= 1'b0;
      r_mode <= 1'b0;
      r_dir  <= 1'b0;
    end else begin
      r_pre  <= (w_clr || r_state == ST_IDLE || r_state == ST_DONE) ? '0 :
                (r_state != ST_RUN) ? r_pre :
                w_due ? ((w_next == ST_RUN) ? '0 : r_pre) : r_pre + 1'b1;
      r_en   <= w_due && (w_next == ST_RUN);
      r_clr  <= w_clr;
      r_mode <= (r_state != ST_RUN) ? w_mode_s : r_mode;
      r_dir  <= (r_state != ST_RUN) ? w_dir_s : r_dir;
    end

  always_comb begin
    running       = r_state == ST_RUN;
    done          = r_state == ST_DONE;
    state         = r_state;
    cnt_enable    = r_en;
    cnt_clear     = r_clr;
    cnt_mode      = r_mode;
    cnt_direction = r_dir;
  end
endmodule

// File: tb/tb_decade_chain_ctrl.sv
// tb_decade_chain_ctrl: directed vector table plus hand sequences, DIV=10
module tb_decade_chain_ctrl;
  logic clk = 1'b0, reset_n = 1'b0;
  logic btn_start_stop = 1'b0, btn_clear = 1'b0;
  logic sw_mode = 1'b0, sw_dir = 1'b0, sw_oneshot = 1'b0, chain_terminal = 1'b0;
  logic cnt_enable, cnt_clear, cnt_mode, cnt_direction, running, done;
  logic [1:0] state;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  decade_chain_ctrl #(.CLK_HZ(10), .TICK_HZ(1), .DIV_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .btn_start_stop(btn_start_stop), .btn_clear(btn_clear),
    .sw_mode(sw_mode), .sw_dir(sw_dir), .sw_oneshot(sw_oneshot), .chain_terminal(chain_terminal),
    .cnt_enable(cnt_enable), .cnt_clear(cnt_clear), .cnt_mode(cnt_mode),
    .cnt_direction(cnt_direction), .running(running), .done(done), .state(state)
  );

  wire [7:0] w_obs = {state, running, done, cnt_enable, cnt_clear, cnt_mode, cnt_direction};

  typedef struct {
    logic       st;
    logic       md;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input int n, input logic st, input logic md, input logic [1:0] s, input logic en);
    vec_t v;
    v.st  = st;
    v.md  = md;
    v.exp = {s, s == 2'd1, s == 2'd3, en, 3'b000};
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_start();
    btn_start_stop = 1'b1;
    step();
    btn_start_stop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k, n_en, n_clr, n_bad;
    // press held 4 cycles; RUN at 4th edge, ticks 10 and 20 cycles later; sw_mode flipped during RUN
    add(3, 1'b1, 1'b0, 2'd0, 1'b0);
    add(1, 1'b1, 1'b0, 2'd1, 1'b0);
    add(9, 1'b0, 1'b1, 2'd1, 1'b0);
    add(1, 1'b0, 1'b1, 2'd1, 1'b1);
    add(9, 1'b0, 1'b1, 2'd1, 1'b0);
    add(1, 1'b0, 1'b1, 2'd1, 1'b1);
    add(1, 1'b0, 1'b1, 2'd1, 1'b0);
    #12;
    chk("reset_outputs", {24'd0, w_obs}, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    foreach (tbl[i]) begin
      btn_start_stop = tbl[i].st;
      sw_mode        = tbl[i].md;
      step();
      chk($sformatf("vec%0d", i), {24'd0, w_obs}, {24'd0, tbl[i].exp});
    end
    // pause: prescaler holds 5, mode follows switch while paused
    press_start();
    step();
    step();
    chk("pause_not_yet", {30'd0, state}, 32'd1);
    step();
    chk("pause_entry", {30'd0, state}, 32'd2);
    k = 0;
    while (k < 3 && !cnt_mode) begin
      step();
      k++;
    end
    chk("mode_follow_pause", {31'd0, cnt_mode}, 32'd1);
    n_en = 0;
    repeat (18) begin
      step();
      n_en += int'(cnt_enable);
    end
    chk("no_tick_pause", n_en, 0);
    press_start();
    step();
    step();
    chk("still_pause", {30'd0, state}, 32'd2);
    step();
    chk("resume_run", {30'd0, state}, 32'd1);
    sw_mode = 1'b0;
    k = 0;
    do begin
      step();
      k++;
    end while (!cnt_enable && k < 12);
    chk("resume_tick_delay", k, 5);
    chk("mode_frozen_run", {31'd0, cnt_mode}, 32'd1);
    // oneshot with terminal chain: next due tick is swallowed and FSM parks in DONE
    sw_oneshot     = 1'b1;
    chain_terminal = 1'b1;
    k = 0;
    n_en = 0;
    do begin
      step();
      k++;
      n_en += int'(cnt_enable);
    end while (state == 2'd1 && k < 20);
    chk("oneshot_steps", k, 10);
    chk("oneshot_tick_suppressed", n_en, 0);
    chk("done_outputs", {24'd0, w_obs}, {24'd0, 8'b11_0_1_0_0_1_0});
    chain_terminal = 1'b0;
    press_start();
    repeat (5) step();
    chk("done_ignores_start", {30'd0, state}, 32'd3);
    btn_clear = 1'b1;
    step();
    btn_clear = 1'b0;
    step();
    step();
    chk("clear_not_yet", {29'd0, state, cnt_clear}, {29'd0, 2'd3, 1'b0});
    step();
    chk("clear_pulse", {28'd0, state, cnt_clear, cnt_enable}, {28'd0, 2'd0, 1'b1, 1'b0});
    step();
    chk("clear_one_cycle", {31'd0, cnt_clear}, 32'd0);
    sw_oneshot = 1'b0;
    // simultaneous clear and start while running
    press_start();
    repeat (3) step();
    chk("run_again", {30'd0, state}, 32'd1);
    repeat (2) step();
    btn_start_stop = 1'b1;
    btn_clear      = 1'b1;
    step();
    btn_start_stop = 1'b0;
    btn_clear      = 1'b0;
    repeat (3) step();
    chk("clr_start_same", {29'd0, state, cnt_clear}, {29'd0, 2'd0, 1'b1});
    n_en = 0;
    n_clr = 0;
    n_bad = 0;
    repeat (25) begin
      step();
      n_en  += int'(cnt_enable);
      n_clr += int'(cnt_clear);
      if (state != 2'd0) n_bad++;
    end
    chk("no_tick_after_clear", n_en, 0);
    chk("single_clear_pulse", n_clr, 0);
    chk("idle_after_clear", n_bad, 0);
    // asynchronous reset between edges while a tick is being driven
    sw_mode = 1'b1;
    sw_dir  = 1'b1;
    repeat (3) step();
    press_start();
    repeat (3) step();
    chk("run_before_reset", {30'd0, state}, 32'd1);
    k = 0;
    while (!cnt_enable && k < 15) begin
      step();
      k++;
    end
    chk("tick_before_reset", {29'd0, cnt_enable, cnt_mode, cnt_direction}, 32'd7);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset", {24'd0, w_obs}, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    n_en = 0;
    n_bad = 0;
    repeat (30) begin
      step();
      n_en += int'(cnt_enable);
      if (state != 2'd0) n_bad++;
    end
    chk("no_tick_after_reset", n_en, 0);
    chk("idle_after_reset", n_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
